lcd_bus_receiver: RTL and testbench

- Display-side responder for the 8-bit 8080-style write bus (wr, dcx, D) driven by pixel_updater.
- Decodes the command/parameter stream: SWRESET, SLPOUT, DISPON, CASET, PASET and RAMWR.
- Tracks the column/page window and the write cursor, assembles RGB565 pixels, and emits one frame-buffer write per pixel.
- Acts as a behavioural display model in simulation and as a front end for an on-chip frame buffer.

---
 rtl/lcd_bus_receiver.sv | 174 +++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_receiver.sv
// Display-side responder for an 8080-style 8-bit write bus: decodes commands,
// tracks the CASET/PASET window and write cursor, and emits one write per RGB565 pixel.
module lcd_bus_receiver #(
  parameter int unsigned COLS = 240,
  parameter int unsigned ROWS = 320,
  parameter int unsigned AW   = 9
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          wr,
  input  logic          dcx,
  input  logic [7:0]    D,
  output logic          pix_we,
  output logic [AW-1:0] pix_x,
  output logic [AW-1:0] pix_y,
  output logic [15:0]   pix_data,
  output logic          cmd_valid,
  output logic [7:0]    cmd_code,
  output logic          sleep_out,
  output logic          display_on,
  output logic          param_err
);

  localparam logic [15:0]   COLS_W = 16'(COLS);
  localparam logic [15:0]   ROWS_W = 16'(ROWS);
  localparam logic [AW-1:0] EC_RST = AW'(COLS - 1);
  localparam logic [AW-1:0] ER_RST = AW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CASET_P, S_PASET_P, S_RAM_HI, S_RAM_LO, S_SKIP
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_wr_d;
  logic [1:0]    r_pcnt;
  logic [7:0]    r_p0, r_p1, r_p2, r_hi;
  logic [AW-1:0] r_sc, r_ec, r_sr, r_er, r_cx, r_cy;

  logic          w_ev, w_cmd, w_dat, w_win_ok, w_x_wrap;
  logic [15:0]   w_start, w_end, w_lim;
  logic [AW-1:0] w_cx_nxt, w_cy_nxt;

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    if (w_cmd) begin
      case (D)
        8'h2A:                      w_state_nxt = S_CASET_P;
        8'h2B:                      w_state_nxt = S_PASET_P;
        8'h2C:                      w_state_nxt = S_RAM_HI;
        8'h01, 8'h11, 8'h28, 8'h29: w_state_nxt = S_IDLE;
        default:                    w_state_nxt = S_SKIP;
      endcase
    end else if (w_dat) begin
      case (r_state)
        S_CASET_P, S_PASET_P: if (r_pcnt == 2'd3) w_state_nxt = S_IDLE;
        S_RAM_HI:             w_state_nxt = S_RAM_LO;
        S_RAM_LO:             w_state_nxt = S_RAM_HI;
        default:              w_state_nxt = r_state;
      endcase
    end
  end

  // Byte event, window validation and cursor advance
  always_comb begin
    w_ev     = wr & ~r_wr_d;
    w_cmd    = w_ev & ~dcx;
    w_dat    = w_ev & dcx;
    w_start  = {r_p0, r_p1};
    w_end    = {r_p2, D};
    w_lim    = (r_state == S_PASET_P) ? ROWS_W : COLS_W;
    w_win_ok = (w_start <= w_end) && (w_end < w_lim);
    w_x_wrap = (r_cx == r_ec);
    w_cx_nxt = w_x_wrap ? r_sc : r_cx + AW'(1);
    w_cy_nxt = r_cy;
    if (w_x_wrap) w_cy_nxt = (r_cy == r_er) ? r_sr : r_cy + AW'(1);
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_d     <= 1'b0;
      r_pcnt     <= 2'd0;
      r_p0       <= 8'd0;
      r_p1       <= 8'd0;
      r_p2       <= 8'd0;
      r_hi       <= 8'd0;
      r_sc       <= '0;
      r_ec       <= EC_RST;
      r_sr       <= '0;
      r_er       <= ER_RST;
      r_cx       <= '0;
      r_cy       <= '0;
      pix_we     <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= 16'd0;
      cmd_valid  <= 1'b0;
      cmd_code   <= 8'd0;
      sleep_out  <= 1'b0;
      display_on <= 1'b0;
      param_err  <= 1'b0;
    end else begin
      r_wr_d    <= wr;
      pix_we    <= 1'b0;
      cmd_valid <= 1'b0;
      param_err <= 1'b0;
      if (w_cmd) begin
        cmd_valid <= 1'b1;
        cmd_code  <= D;
        r_pcnt    <= 2'd0;
        case (D)
          8'h01: begin
            r_sc       <= '0;
            r_ec       <= EC_RST;
            r_sr       <= '0;
            r_er       <= ER_RST;
            r_cx       <= '0;
            r_cy       <= '0;
            sleep_out  <= 1'b0;
            display_on <= 1'b0;
          end
          8'h11: sleep_out  <= 1'b1;
          8'h29: display_on <= 1'b1;
          8'h28: display_on <= 1'b0;
          8'h2C: begin
            r_cx <= r_sc;
            r_cy <= r_sr;
          end
          default: ;
        endcase
      end else if (w_dat) begin
        case (r_state)
          S_CASET_P, S_PASET_P: begin
            r_pcnt <= r_pcnt + 2'd1;
            case (r_pcnt)
              2'd0: r_p0 <= D;
              2'd1: r_p1 <= D;
              2'd2: r_p2 <= D;
              default: begin
                if (!w_win_ok) begin
                  param_err <= 1'b1;
                end else if (r_state == S_CASET_P) begin
                  r_sc <= AW'(w_start);
                  r_ec <= AW'(w_end);
                end else begin
                  r_sr <= AW'(w_start);
                  r_er <= AW'(w_end);
                end
              end
            endcase
          end
          S_RAM_HI: r_hi <= D;
          S_RAM_LO: begin
            pix_we   <= 1'b1;
            pix_x    <= r_cx;
            pix_y    <= r_cy;
            pix_data <= {r_hi, D};
            r_cx     <= w_cx_nxt;
            r_cy     <= w_cy_nxt;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Randomized scoreboard bench for lcd_bus_receiver against a high-level display model.
module tb_lcd_bus_receiver;
  localparam int COLS = 240;
  localparam int ROWS = 320;
  localparam int AW   = 9;
  localparam int M_NONE = 0, M_COL = 1, M_ROW = 2, M_PIX = 3;

  logic          clk, nrst, wr, dcx;
  logic [7:0]    D;
  logic          pix_we, cmd_valid, sleep_out, display_on, param_err;
  logic [AW-1:0] pix_x, pix_y;
  logic [15:0]   pix_data;
  logic [7:0]    cmd_code;

  lcd_bus_receiver #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
    .clk(clk), .nrst(nrst), .wr(wr), .dcx(dcx), .D(D),
    .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .sleep_out(sleep_out),
    .display_on(display_on), .param_err(param_err)
  );

  typedef struct { int x; int y; int data; int cyc; } pix_t;
  typedef struct { int code; int cyc; } cmd_t;
  typedef struct { int cyc; bit sl; bit dp; int code; } flag_t;

  pix_t  pix_q[$];
  cmd_t  cmd_q[$];
  int    err_q[$];
  flag_t flag_q[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit done = 0;
  bit finished = 0;

  // Model state
  int m_sc, m_ec, m_sr, m_er, m_cx, m_cy, m_mode, m_hi, m_code;
  bit m_has_hi, m_sleep, m_disp;
  int m_par[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_reset();
    m_sc = 0; m_ec = COLS - 1; m_sr = 0; m_er = ROWS - 1;
    m_cx = 0; m_cy = 0; m_mode = M_NONE; m_has_hi = 0; m_hi = 0;
    m_sleep = 0; m_disp = 0; m_code = 0;
    m_par.delete();
  endfunction

  function automatic void model_byte(input bit dc, input int b, input int c);
    int s, e, lim;
    pix_t p;
    cmd_t k;
    flag_t f;
    if (!dc) begin
      k.code = b; k.cyc = c; cmd_q.push_back(k);
      m_code = b; m_par.delete(); m_has_hi = 0; m_mode = M_NONE;
      case (b)
        'h01: begin
          m_sc = 0; m_ec = COLS - 1; m_sr = 0; m_er = ROWS - 1;
          m_cx = 0; m_cy = 0; m_sleep = 0; m_disp = 0;
        end
        'h11: m_sleep = 1;
        'h29: m_disp = 1;
        'h28: m_disp = 0;
        'h2A: m_mode = M_COL;
        'h2B: m_mode = M_ROW;
        'h2C: begin m_cx = m_sc; m_cy = m_sr; m_mode = M_PIX; end
        default: m_mode = M_NONE;
      endcase
    end else if (m_mode == M_COL || m_mode == M_ROW) begin
      m_par.push_back(b);
      if (m_par.size() == 4) begin
        s = m_par[0] * 256 + m_par[1];
        e = m_par[2] * 256 + m_par[3];
        lim = (m_mode == M_COL) ? COLS : ROWS;
        if (s <= e && e < lim) begin
          if (m_mode == M_COL) begin m_sc = s; m_ec = e; end
          else begin m_sr = s; m_er = e; end
        end else err_q.push_back(c);
        m_mode = M_NONE;
      end
    end else if (m_mode == M_PIX) begin
      if (!m_has_hi) begin
        m_hi = b; m_has_hi = 1;
      end else begin
        p.x = m_cx; p.y = m_cy; p.data = m_hi * 256 + b; p.cyc = c;
        pix_q.push_back(p);
        m_has_hi = 0;
        if (m_cx == m_ec) begin
          m_cx = m_sc;
          m_cy = (m_cy == m_er) ? m_sr : m_cy + 1;
        end else m_cx = m_cx + 1;
      end
    end
    f.cyc = c; f.sl = m_sleep; f.dp = m_disp; f.code = m_code;
    flag_q.push_back(f);
  endfunction

  task automatic send(input bit dc, input int b);
    @(negedge clk);
    wr = 1'b0; dcx = dc; D = 8'(b);
    repeat ($urandom_range(0, 1)) @(negedge clk);
    @(negedge clk);
    wr = 1'b1;
    model_byte(dc, b, cyc + 1);
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  task automatic send_list(input bit dc0, input int n, input int bytes[12]);
    send(0, bytes[0]);
    for (int i = 1; i < n; i++) send(dc0, bytes[i]);
  endtask

  function automatic int pick_cmd();
    case ($urandom_range(0, 9))
      0: return 'h01;
      1: return 'h11;
      2: return 'h29;
      3: return 'h28;
      4: return 'h2A;
      5: return 'h2B;
      6: return 'h36;
      default: return 'h2C;
    endcase
  endfunction

  function automatic int gen_data();
    if ((m_mode == M_COL || m_mode == M_ROW) && (m_par.size() % 2 == 0))
      return $urandom_range(0, 1);
    return $urandom_range(0, 255);
  endfunction

  task automatic chk(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an output
  always @(negedge clk) begin
    pix_t  p;
    cmd_t  k;
    flag_t f;
    int    e;
    if (!nrst) begin
      chk({pix_we, pix_x, pix_y, pix_data, cmd_valid, cmd_code, sleep_out,
           display_on, param_err} == '0, "reset_outputs",
          $sformatf("got we=%0b x=%0d y=%0d data=%h cv=%0b code=%h sl=%0b dp=%0b pe=%0b want all 0",
                    pix_we, pix_x, pix_y, pix_data, cmd_valid, cmd_code, sleep_out,
                    display_on, param_err));
    end else begin
      if (pix_we) begin
        if (pix_q.size() == 0) chk(1'b0, "pix_unexpected", $sformatf("got write at cyc %0d, want none", cyc));
        else begin
          p = pix_q.pop_front();
          chk(int'(pix_x) == p.x && int'(pix_y) == p.y && int'(pix_data) == p.data && cyc == p.cyc,
              "pix_write", $sformatf("got (%0d,%0d) %h cyc %0d want (%0d,%0d) %h cyc %0d",
                                      pix_x, pix_y, pix_data, cyc, p.x, p.y, p.data[15:0], p.cyc));
        end
      end else if (pix_q.size() != 0 && pix_q[0].cyc <= cyc) begin
        p = pix_q.pop_front();
        chk(1'b0, "pix_missing", $sformatf("got no write at cyc %0d want (%0d,%0d) %h", cyc, p.x, p.y, p.data[15:0]));
      end
      if (cmd_valid) begin
        if (cmd_q.size() == 0) chk(1'b0, "cmd_unexpected", $sformatf("got cmd_valid at cyc %0d, want none", cyc));
        else begin
          k = cmd_q.pop_front();
          chk(int'(cmd_code) == k.code && cyc == k.cyc, "cmd_valid",
              $sformatf("got code %h cyc %0d want %h cyc %0d", cmd_code, cyc, k.code[7:0], k.cyc));
        end
      end else if (cmd_q.size() != 0 && cmd_q[0].cyc <= cyc) begin
        k = cmd_q.pop_front();
        chk(1'b0, "cmd_missing", $sformatf("got no cmd_valid at cyc %0d want code %h", cyc, k.code[7:0]));
      end
      if (param_err) begin
        if (err_q.size() == 0) chk(1'b0, "perr_unexpected", $sformatf("got param_err at cyc %0d, want none", cyc));
        else begin
          e = err_q.pop_front();
          chk(cyc == e, "param_err", $sformatf("got pulse cyc %0d want cyc %0d", cyc, e));
        end
      end else if (err_q.size() != 0 && err_q[0] <= cyc) begin
        e = err_q.pop_front();
        chk(1'b0, "perr_missing", $sformatf("got no param_err at cyc %0d want cyc %0d", cyc, e));
      end
      if (flag_q.size() != 0 && flag_q[0].cyc <= cyc) begin
        f = flag_q.pop_front();
        chk(sleep_out == f.sl && display_on == f.dp && int'(cmd_code) == f.code, "status",
            $sformatf("got sl=%0b dp=%0b code=%h want sl=%0b dp=%0b code=%h",
                      sleep_out, display_on, cmd_code, f.sl, f.dp, f.code[7:0]));
      end
    end
    if (done && !finished) begin
      chk(pix_q.size() == 0 && cmd_q.size() == 0 && err_q.size() == 0 && flag_q.size() == 0,
          "drain", $sformatf("got pending pix=%0d cmd=%0d err=%0d flag=%0d want 0",
                             pix_q.size(), cmd_q.size(), err_q.size(), flag_q.size()));
      finished = 1;
    end
  end

  initial begin
    int seq[12];
    nrst = 1'b0; wr = 1'b0; dcx = 1'b0; D = 8'h00;
    model_reset();
    repeat (4) @(negedge clk);
    #2 nrst = 1'b1;
    repeat (3) @(negedge clk);

    send(0, 'h11); send(0, 'h29); send(0, 'h01);
    seq = '{'h2A, 'h00, 'h0A, 'h00, 'h0B, 0, 0, 0, 0, 0, 0, 0}; send_list(1, 5, seq);
    seq = '{'h2B, 'h00, 'h14, 'h00, 'h15, 0, 0, 0, 0, 0, 0, 0}; send_list(1, 5, seq);
    seq = '{'h2C, 'hF8, 'h00, 'h07, 'hE0, 'h00, 'h1F, 'hFF, 'hFF, 'h12, 'h34, 0};
    send_list(1, 11, seq);
    seq = '{'h2A, 'h00, 'h05, 'h00, 'h02, 'h77, 0, 0, 0, 0, 0, 0}; send_list(1, 6, seq);
    seq = '{'h2A, 'h00, 'h00, 'h00, 'hF0, 0, 0, 0, 0, 0, 0, 0}; send_list(1, 5, seq);
    seq = '{'h2B, 'h00, 'h00, 'h01, 'h40, 0, 0, 0, 0, 0, 0, 0}; send_list(1, 5, seq);
    seq = '{'h2C, 'hAB, 'hCD, 0, 0, 0, 0, 0, 0, 0, 0, 0}; send_list(1, 3, seq);
    seq = '{'h2C, 'hAB, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}; send_list(1, 2, seq);
    seq = '{'h2C, 'h12, 'h34, 0, 0, 0, 0, 0, 0, 0, 0, 0}; send_list(1, 3, seq);
    seq = '{'h36, 'h48, 'h12, 'h34, 0, 0, 0, 0, 0, 0, 0, 0}; send_list(1, 4, seq);
    seq = '{'h2A, 'h00, 'hEE, 'h00, 'hEF, 0, 0, 0, 0, 0, 0, 0}; send_list(1, 5, seq);
    seq = '{'h2B, 'h01, 'h3E, 'h01, 'h3F, 0, 0, 0, 0, 0, 0, 0}; send_list(1, 5, seq);
    seq = '{'h2C, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0}; send_list(1, 11, seq);

    repeat (400) begin
      if ($urandom_range(0, 99) < 15) send(0, pick_cmd());
      else send(1, gen_data());
    end

    send(0, 'h2C); send(1, 'hAB);
    repeat (3) @(negedge clk);
    #2 nrst = 1'b0;
    wr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #2 nrst = 1'b1;
    send(1, 'h34); send(1, 'h56);
    repeat (5) @(negedge clk);
    done = 1;
    for (int i = 0; i < 20 && !finished; i++) @(negedge clk);
    if (!finished) begin
      $display("FAIL monitor_timeout: got no drain check want drain within 20 cycles");
      $fatal(1, "monitor did not finish");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
